top_level: RTL and testbench

TOP_LEVEL -- requirements
Module: top_level

---
 rtl/top_level.sv | 175 +++++++++++++++++
 tb/tb_top_level.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_level.sv
// WSPR beacon core: loads a 21-byte configuration, packs and encodes the
// message into 162 4-FSK symbols, then keys them onto a phase-accumulator NCO.
//
// state  | meaning
// IDLE   | after reset, waiting for io_config_start
// LOAD   | collecting configuration bytes 0..20
// ENCODE | pack, convolutional encode, interleave (338 clocks)
// READY  | symbols valid, waiting for io_rf_start
// TX     | emitting symbols 0..161, each held for the symbol period
module top_level (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] io_config_bits_in,
  input  logic       io_config_valid_in,
  input  logic       io_config_start,
  input  logic       io_rf_start,
  output logic       io_rf_out,
  output logic [1:0] io_bit_out
);

  typedef enum logic [2:0] {IDLE, LOAD, ENCODE, READY, TX} state_t;

  localparam logic [31:0] POLY_A = 32'hF2D05351;
  localparam logic [31:0] POLY_B = 32'hE4613C47;
  // Leftmost literal bit is sync[0]; sync[k] lives at bit 161-k.
  localparam logic [161:0] SYNC_VEC =
    162'b11000000100011100010_01011110000000100101_00000010110011010001_10100001101010101001_00101100011010100010_00001001001110110011_01000111000001010011_00000001101011000110_00;

  state_t         state;
  logic [7:0]     cfg [0:20];
  logic [4:0]     byte_idx;
  logic [8:0]     enc_step;
  logic [80:0]    msg;
  logic [31:0]    conv_sreg;
  logic [161:0]   enc_bits;
  logic [161:0]   data_bits;
  logic [7:0]     sym_idx;
  logic [31:0]    sym_timer;
  logic [31:0]    acc;
  logic [1:0]     sym_cur;

  logic [27:0]    n_val;
  logic [21:0]    m_val;
  logic [21:0]    m_pack;
  logic [31:0]    period_cfg;
  logic [31:0]    period_reload;
  logic [31:0]    base_cfg;
  logic [15:0]    step_cfg;
  logic [31:0]    acc_inc;
  logic [31:0]    sreg_next;
  logic [7:0]     ilv_i;
  logic [7:0]     ilv_j;
  logic [1:0]     sym_first;
  logic [1:0]     sym_next;

  function automatic logic [5:0] char_code(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39) return 6'(ch - 8'h30);
    else if (ch >= 8'h41 && ch <= 8'h5A) return 6'(ch - 8'h37);
    else return 6'd36;
  endfunction

  // Both packs are exact modulo their field width, so narrow arithmetic suffices.
  always_comb begin
    n_val = {22'd0, char_code(cfg[0])};
    n_val = n_val * 28'd36 + {22'd0, char_code(cfg[1])};
    n_val = n_val * 28'd10 + {22'd0, char_code(cfg[2])};
    for (int k = 3; k < 6; k++)
      n_val = n_val * 28'd27 + {22'd0, char_code(cfg[k])} - 28'd10;
    m_val = (22'd179 - 22'd10 * ({14'd0, cfg[6]} - 22'd65) - ({14'd0, cfg[8]} - 22'd48)) * 22'd180
          + 22'd10 * ({14'd0, cfg[7]} - 22'd65) + ({14'd0, cfg[9]} - 22'd48);
    m_pack = m_val * 22'd128 + {14'd0, cfg[10]} + 22'd64;
  end

  always_comb begin
    ilv_i = enc_step[7:0] - 8'd82;
    for (int b = 0; b < 8; b++) ilv_j[b] = ilv_i[7-b];
  end

  assign period_cfg    = {cfg[11], cfg[12], cfg[13], cfg[14]};
  assign base_cfg      = {cfg[15], cfg[16], cfg[17], cfg[18]};
  assign step_cfg      = {cfg[19], cfg[20]};
  assign period_reload = (period_cfg == 32'd0) ? 32'd0 : period_cfg - 32'd1;
  assign acc_inc       = base_cfg + {30'd0, sym_cur} * {16'd0, step_cfg};
  assign sreg_next     = {conv_sreg[30:0], msg[80]};
  assign sym_first     = {data_bits[0], SYNC_VEC[161]};
  assign sym_next      = {data_bits[sym_idx + 8'd1], SYNC_VEC[8'd160 - sym_idx]};

  assign io_rf_out  = acc[31];
  assign io_bit_out = sym_cur;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      byte_idx  <= 5'd0;
      for (int i = 0; i < 21; i++) cfg[i] <= 8'd0;
      enc_step  <= 9'd0;
      msg       <= '0;
      conv_sreg <= 32'd0;
      enc_bits  <= '0;
      data_bits <= '0;
      sym_idx   <= 8'd0;
      sym_timer <= 32'd0;
      acc       <= 32'd0;
      sym_cur   <= 2'd0;
    end else if (io_config_start) begin
      state     <= LOAD;
      byte_idx  <= 5'd0;
      enc_step  <= 9'd0;
      sym_idx   <= 8'd0;
      sym_timer <= 32'd0;
      acc       <= 32'd0;
      sym_cur   <= 2'd0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          if (io_config_valid_in) begin
            cfg[byte_idx] <= io_config_bits_in;
            byte_idx      <= byte_idx + 5'd1;
            if (byte_idx == 5'd20) begin
              state    <= ENCODE;
              enc_step <= 9'd0;
            end
          end
        end
        ENCODE: begin
          enc_step <= enc_step + 9'd1;
          if (enc_step == 9'd0) begin
            msg       <= {n_val, m_pack, 31'd0};
            conv_sreg <= 32'd0;
          end else if (enc_step <= 9'd81) begin
            conv_sreg <= sreg_next;
            msg       <= {msg[79:0], 1'b0};
            enc_bits  <= {^(sreg_next & POLY_B), ^(sreg_next & POLY_A), enc_bits[161:2]};
          end else begin
            // enc_bits drains LSB-first, so enc_bits[0] is always the next encoded bit
            if (ilv_j < 8'd162) begin
              data_bits[ilv_j] <= enc_bits[0];
              enc_bits         <= {1'b0, enc_bits[161:1]};
            end
            if (enc_step == 9'd337) state <= READY;
          end
        end
        READY: begin
          if (io_rf_start) begin
            state     <= TX;
            sym_idx   <= 8'd0;
            sym_timer <= period_reload;
            sym_cur   <= sym_first;
            acc       <= 32'd0;
          end
        end
        TX: begin
          acc <= acc + acc_inc;
          if (sym_timer == 32'd0) begin
            if (sym_idx == 8'd161) begin
              state   <= READY;
              sym_idx <= 8'd0;
              sym_cur <= 2'd0;
              acc     <= 32'd0;
            end else begin
              sym_idx   <= sym_idx + 8'd1;
              sym_timer <= period_reload;
              sym_cur   <= sym_next;
            end
          end else begin
            sym_timer <= sym_timer - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_level.sv
// Bench for the WSPR core: reference encoder builds the expected symbol and
// NCO trace; table of configurations plus abort/reset corner sequences.
module tb_top_level;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] io_config_bits_in = 8'd0;
  logic       io_config_valid_in = 1'b0;
  logic       io_config_start = 1'b0;
  logic       io_rf_start = 1'b0;
  logic       io_rf_out;
  logic [1:0] io_bit_out;

  top_level dut (
    .clock(clock),
    .reset(reset),
    .io_config_bits_in(io_config_bits_in),
    .io_config_valid_in(io_config_valid_in),
    .io_config_start(io_config_start),
    .io_rf_start(io_rf_start),
    .io_rf_out(io_rf_out),
    .io_bit_out(io_bit_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       call;
    string       loc;
    int          power;
    logic [31:0] period;
    logic [31:0] base;
    logic [15:0] step;
    int          n_bytes;
    bit          hold_rf;
    bit          expect_tx;
  } vec_t;

  typedef struct {
    logic [1:0] sym;
    logic       rf;
  } exp_t;

  localparam logic [161:0] SYNC_REF =
    162'b11000000100011100010_01011110000000100101_00000010110011010001_10100001101010101001_00101100011010100010_00001001001110110011_01000111000001010011_00000001101011000110_00;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  logic [7:0] cfg_b [21];
  int   sym_m [162];
  vec_t vecs [5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int cc(input byte ch);
    if (ch >= "0" && ch <= "9") return int'(ch) - 48;
    if (ch >= "A" && ch <= "Z") return int'(ch) - 55;
    return 36;
  endfunction

  task automatic build_model(input vec_t v);
    longint n, m;
    bit     msgb [81];
    int     enc [162];
    int     data [162];
    logic [31:0] r;
    logic [7:0]  iv, jv;
    int p;
    n = cc(v.call[0]);
    n = n * 36 + cc(v.call[1]);
    n = n * 10 + cc(v.call[2]);
    for (int k = 3; k < 6; k++) n = n * 27 + cc(v.call[k]) - 10;
    m = (179 - 10 * (int'(v.loc[0]) - 65) - (int'(v.loc[2]) - 48)) * 180
      + 10 * (int'(v.loc[1]) - 65) + (int'(v.loc[3]) - 48);
    m = m * 128 + v.power + 64;
    for (int i = 0; i < 81; i++) msgb[i] = 1'b0;
    for (int i = 0; i < 28; i++) msgb[i] = n[27-i];
    for (int i = 0; i < 22; i++) msgb[28+i] = m[21-i];
    r = 32'd0;
    for (int i = 0; i < 81; i++) begin
      r = {r[30:0], msgb[i]};
      enc[2*i]   = int'(^(r & 32'hF2D05351));
      enc[2*i+1] = int'(^(r & 32'hE4613C47));
    end
    p = 0;
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      for (int b = 0; b < 8; b++) jv[b] = iv[7-b];
      if (jv < 8'd162) begin
        data[jv] = enc[p];
        p++;
      end
    end
    for (int k = 0; k < 162; k++) sym_m[k] = int'(SYNC_REF[161-k]) + 2 * data[k];
    for (int k = 0; k < 6; k++) cfg_b[k] = v.call[k];
    for (int k = 0; k < 4; k++) cfg_b[6+k] = v.loc[k];
    cfg_b[10] = 8'(v.power);
    for (int k = 0; k < 4; k++) cfg_b[11+k] = v.period[31-8*k -: 8];
    for (int k = 0; k < 4; k++) cfg_b[15+k] = v.base[31-8*k -: 8];
    cfg_b[19] = v.step[15:8];
    cfg_b[20] = v.step[7:0];
  endtask

  task automatic check_out(input string name, input exp_t e);
    vectors++;
    if (io_bit_out !== e.sym || io_rf_out !== e.rf) begin
      miscompares++;
      $display("FAIL %s @%0t: got bit_out=%0d rf_out=%0b, expected bit_out=%0d rf_out=%0b",
               name, $time, io_bit_out, io_rf_out, e.sym, e.rf);
    end
  endtask

  task automatic send_bytes(input bit with_start, input int n);
    if (with_start) begin
      io_config_start = 1'b1;
      io_config_valid_in = 1'b1;
      io_config_bits_in = 8'hFF;
      tick();
      io_config_start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      io_config_valid_in = 1'b1;
      io_config_bits_in = cfg_b[i];
      tick();
    end
    if (n == 21) begin
      for (int i = 0; i < 3; i++) begin
        io_config_bits_in = 8'hA5;
        tick();
      end
    end
    io_config_valid_in = 1'b0;
    io_config_bits_in = 8'd0;
  endtask

  task automatic wait_tx_start(input string name, output bit ok);
    int w;
    w = 0;
    while (io_bit_out == 2'd0 && w < 1100) begin
      tick();
      w++;
    end
    ok = (io_bit_out != 2'd0);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: no TX start after %0d clocks, bit_out=%0d required nonzero", name, w, io_bit_out);
    end
  endtask

  task automatic expect_idle(input string name, input int cycles);
    bit seen;
    logic [1:0] fb;
    logic fr;
    seen = 1'b0;
    fb = 2'd0;
    fr = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (!seen && (io_bit_out != 2'd0 || io_rf_out != 1'b0)) begin
        seen = 1'b1;
        fb = io_bit_out;
        fr = io_rf_out;
      end
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL %s: outputs went bit_out=%0d rf_out=%0b, required 0/0", name, fb, fr);
    end
  endtask

  task automatic run_tx(input string name, input vec_t v, input bit hold);
    bit ok;
    int per;
    logic [31:0] acc_m;
    exp_t e;
    bit first;
    io_rf_start = 1'b1;
    wait_tx_start(name, ok);
    if (!ok) begin
      io_rf_start = 1'b0;
      return;
    end
    per = (v.period == 32'd0) ? 1 : int'(v.period);
    acc_m = 32'd0;
    for (int n = 0; n < 162 * per; n++) begin
      e.sym = 2'(sym_m[n / per]);
      e.rf  = acc_m[31];
      exp_q.push_back(e);
      acc_m = acc_m + v.base + 32'(sym_m[n / per]) * {16'd0, v.step};
    end
    e.sym = 2'd0;
    e.rf  = 1'b0;
    exp_q.push_back(e);
    if (hold) begin
      e.sym = 2'(sym_m[0]);
      e.rf  = 1'b0;
      exp_q.push_back(e);
    end else begin
      io_rf_start = 1'b0;
    end
    first = 1'b1;
    while (exp_q.size() > 0) begin
      if (!first) tick();
      first = 1'b0;
      e = exp_q.pop_front();
      check_out(name, e);
    end
    io_rf_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    bit ok;
    z.sym = 2'd0;
    z.rf  = 1'b0;

    vecs[0] = '{" K3RTL", "FN20", 13, 32'd4, 32'h6401A36E, 16'h53E3, 21, 1'b0, 1'b1};
    vecs[1] = '{" K1ABC", "FN42", 37, 32'd1, 32'h12345678, 16'h0100, 21, 1'b1, 1'b1};
    vecs[2] = '{" K3RTL", "FN20", 13, 32'd4, 32'h6401A36E, 16'h53E3, 20, 1'b0, 1'b0};
    vecs[3] = '{"PA0XYZ", "JO22", 30, 32'd0, 32'h80000001, 16'h7FFF, 21, 1'b0, 1'b1};
    vecs[4] = '{" W1AW ", "FN31", 23, 32'd3, 32'hFFFFFFF0, 16'hFFFF, 21, 1'b0, 1'b1};

    reset = 1'b0;
    repeat (3) tick();
    check_out("reset_outputs", z);
    reset = 1'b1;
    tick();
    check_out("post_reset_outputs", z);
    io_rf_start = 1'b1;
    expect_idle("rf_start_before_config", 50);
    io_rf_start = 1'b0;

    for (int t = 0; t < 5; t++) begin
      build_model(vecs[t]);
      send_bytes(1'b1, vecs[t].n_bytes);
      if (vecs[t].expect_tx) begin
        run_tx($sformatf("tx_vec%0d", t), vecs[t], vecs[t].hold_rf);
        if (!vecs[t].hold_rf) expect_idle($sformatf("ready_after_tx_vec%0d", t), 20);
      end else begin
        io_rf_start = 1'b1;
        expect_idle($sformatf("no_tx_vec%0d", t), 1200);
        io_rf_start = 1'b0;
      end
    end

    // config_start in the middle of a transmission
    build_model(vecs[0]);
    send_bytes(1'b1, 21);
    io_rf_start = 1'b1;
    wait_tx_start("abort_tx_start", ok);
    repeat (30) tick();
    io_config_start = 1'b1;
    tick();
    io_config_start = 1'b0;
    check_out("abort_outputs_next_clock", z);
    expect_idle("abort_load_ignores_rf", 50);
    io_rf_start = 1'b0;
    build_model(vecs[3]);
    send_bytes(1'b0, 21);
    run_tx("tx_after_abort", vecs[3], 1'b0);

    // reset in the middle of a transmission
    build_model(vecs[1]);
    send_bytes(1'b1, 21);
    io_rf_start = 1'b1;
    wait_tx_start("reset_tx_start", ok);
    repeat (10) tick();
    reset = 1'b0;
    tick();
    check_out("reset_mid_tx_outputs", z);
    reset = 1'b1;
    expect_idle("no_tx_after_reset_mid_tx", 1200);
    io_rf_start = 1'b0;

    // reset in the middle of encoding
    build_model(vecs[0]);
    send_bytes(1'b1, 21);
    repeat (100) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    io_rf_start = 1'b1;
    expect_idle("no_tx_after_reset_mid_encode", 1200);
    io_rf_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
